cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter DWIDTH, default 16, data word width in bits.
REQ-002 Parameter AWIDTH, default 16, byte-address width.
REQ-003 Parameter WORDS, default 8, words per cache line; a power of 2 in the range 2..64.
REQ-004 Parameter IW = log2(WORDS), derived, word-index width.
REQ-005 Single clock and synchronous active-high reset; ports listed below.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 miss_detected  in  1  cache reports a miss this cycle.
REQ-009 miss_addr  in  AWIDTH  byte address of the missing access.
REQ-010 fsm_busy  out  1  pipeline stall request.
REQ-011 mem_req  out  1  memory read request, one word per cycle.
REQ-012 mem_addr  out  AWIDTH  byte address of the requested word.
REQ-013 mem_data_valid  in  1  returned word is valid; returns arrive in request order.
REQ-014 mem_data  in  DWIDTH  returned word.
REQ-015 write_data_array  out  1  write enable for the cache data array.
REQ-016 data_word_idx  out  IW  word index within the line for the data write.
REQ-017 data_out  out  DWIDTH  word to write into the data array.
REQ-018 write_tag_array  out  1  write enable for tag/valid; one-cycle pulse.
REQ-019 fill_done  out  1  one-cycle pulse marking fill completion.

Function
REQ-020 Two states: IDLE and FILL.
REQ-021 IDLE, miss_detected=1: latch line base into base_q and go to FILL next cycle; base = miss_addr with its low IW+1 bits cleared.
REQ-022 fsm_busy is combinational: (state==IDLE & miss_detected) | (state==FILL).
REQ-023 Request counter req_cnt (IW+1 bits): cleared on entry to FILL.
REQ-024 In FILL, mem_req=1 while req_cnt<WORDS; mem_addr=base_q+(req_cnt<<1); req_cnt increments each request cycle.
REQ-025 First mem_req occurs the cycle after the miss cycle; WORDS requests are issued on consecutive cycles.
REQ-026 With mem_req=0, mem_addr holds base_q; it is not X.
REQ-027 Receive counter recv_cnt (IW+1 bits): cleared on entry to FILL.
REQ-028 In FILL, mem_data_valid=1: write_data_array=1, data_word_idx=recv_cnt[IW-1:0], data_out=mem_data, same cycle (combinational pass-through); recv_cnt increments.
REQ-029 mem_data_valid may arrive in the same cycle as any request, including the first; requests and receives advance independently.
REQ-030 Receipt with recv_cnt==WORDS-1: write_tag_array=1 and fill_done=1 in that same cycle; state returns to IDLE next cycle.
REQ-031 mem_data_valid in IDLE is ignored: no array write and no counter change.
REQ-032 miss_detected while in FILL is ignored; the cache reissues the miss after the fill.
REQ-033 IDLE, miss_detected=1 in the cycle after fill_done starts a new fill normally.
REQ-034 mem_data_valid with recv_cnt==WORDS cannot occur; behaviour in that case is unspecified.
REQ-035 Address arithmetic wraps modulo 2^AWIDTH; no carry beyond AWIDTH.
REQ-036 Minimum busy time = 1 + WORDS cycles, reached when each word returns the cycle it is requested.

Reset
REQ-037 rst=1: state=IDLE; req_cnt=recv_cnt=0; base_q=0.
REQ-038 During rst=1, every output is 0 regardless of other inputs.
REQ-039 rst asserted mid-FILL aborts the fill: no further array writes and no tag write; the cache remains invalid for that line.
REQ-040 Memory responses outstanding at reset are discarded by the memory (it shares rst); this block does not drain them.

Verification
REQ-041 WORDS=8, miss_addr=0x1234, 4-cycle memory latency -> mem_addr 0x1230,0x1232,...,0x123E on 8 consecutive cycles; idx 0..7 written in order; tag/fill_done pulse on idx 7; fsm_busy high 1+7+4+1=13 cycles.
REQ-042 Zero-latency memory (valid in the same cycle as each request) -> fill completes in 9 busy cycles; no gap between data writes.
REQ-043 Gapped returns (valid every other cycle) -> idx 0..7 still written in order with matching data; tag written exactly once.
REQ-044 miss_addr=0xFFFA, WORDS=8 -> base 0xFFF0, last address 0xFFFE, no wrap error.
REQ-045 rst asserted after 3 data writes -> next cycle IDLE, all outputs 0, no tag write; a subsequent miss performs a full 8-word fill.
REQ-046 New miss on the cycle after fill_done, plus stray mem_data_valid in IDLE -> the stray data is ignored; the second fill starts one cycle after the second miss.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: on a miss, streams WORDS sequential word reads
// from memory and writes each returned word into the data array, then writes
// the tag/valid entry once the last word has landed.
module cache_fill_ctrl #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 16,
    parameter int unsigned WORDS  = 8,
    localparam int unsigned IW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [AWIDTH-1:0] miss_addr,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              write_data_array,
    output logic [IW-1:0]     data_word_idx,
    output logic [DWIDTH-1:0] data_out,
    output logic              write_tag_array,
    output logic              fill_done
);

    typedef enum logic {StIdle, StFill} state_e;

    localparam logic [IW:0] NumWords = (IW+1)'(WORDS);
    localparam logic [IW:0] LastWord = (IW+1)'(WORDS - 1);

    state_e            state_q, state_d;
    logic [IW:0]       req_cnt_q, req_cnt_d;
    logic [IW:0]       recv_cnt_q, recv_cnt_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [AWIDTH-1:0] line_base;
    logic [AWIDTH-1:0] req_offset;

    // Line base and byte offset of the current request (words are 2 bytes).
    always_comb begin
        line_base           = miss_addr;
        line_base[IW:0]     = '0;
        req_offset          = '0;
        req_offset[IW+1:0]  = {req_cnt_q, 1'b0};
    end

    // Next-state and output decode; reset forces every output low.
    always_comb begin
        state_d          = state_q;
        req_cnt_d        = req_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        base_d           = base_q;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        mem_addr         = base_q;
        write_data_array = 1'b0;
        data_word_idx    = '0;
        data_out         = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (miss_detected) begin
                    fsm_busy   = 1'b1;
                    base_d     = line_base;
                    req_cnt_d  = '0;
                    recv_cnt_d = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                fsm_busy = 1'b1;
                if (req_cnt_q < NumWords) begin
                    mem_req   = 1'b1;
                    mem_addr  = base_q + req_offset;
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (mem_data_valid) begin
                    write_data_array = 1'b1;
                    data_word_idx    = recv_cnt_q[IW-1:0];
                    data_out         = mem_data;
                    recv_cnt_d       = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == LastWord) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_d         = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst) begin
            fsm_busy         = 1'b0;
            mem_req          = 1'b0;
            mem_addr         = '0;
            write_data_array = 1'b0;
            data_word_idx    = '0;
            data_out         = '0;
            write_tag_array  = 1'b0;
            fill_done        = 1'b0;
        end
    end

    // State registers with synchronous reset; reset abandons any fill in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_cnt_q  <= '0;
            recv_cnt_q <= '0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            recv_cnt_q <= recv_cnt_d;
            base_q     <= base_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: a directed vector table, directed
// multi-cycle fill scenarios, then randomized traffic against a reference model.
module tb_cache_fill_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int WORDS = 8;
    localparam int IW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_addr;
    logic          fsm_busy;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_data_valid;
    logic [DW-1:0] mem_data;
    logic          write_data_array;
    logic [IW-1:0] data_word_idx;
    logic [DW-1:0] data_out;
    logic          write_tag_array;
    logic          fill_done;

    always #5 clk = ~clk;

    cache_fill_ctrl #(
        .DWIDTH(DW),
        .AWIDTH(AW),
        .WORDS (WORDS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_detected   (miss_detected),
        .miss_addr       (miss_addr),
        .fsm_busy        (fsm_busy),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_data_valid  (mem_data_valid),
        .mem_data        (mem_data),
        .write_data_array(write_data_array),
        .data_word_idx   (data_word_idx),
        .data_out        (data_out),
        .write_tag_array (write_tag_array),
        .fill_done       (fill_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: fill in progress, line base, words requested / received.
    bit            m_fill  = 0;
    logic [AW-1:0] m_base  = '0;
    int            m_nreq  = 0;
    int            m_nrecv = 0;

    // Memory emulation: in-order responses with a ready cycle each.
    typedef struct {
        int            ready;
        logic [AW-1:0] addr;
    } resp_t;
    resp_t pq[$];
    int    lat_min   = 0;
    int    lat_max   = 0;
    bit    gap_mode  = 0;
    bit    gap_phase = 0;

    // Outputs observed in the most recent cycle.
    bit            o_busy, o_req, o_wr, o_tag, o_done;
    logic [AW-1:0] o_addr;
    logic [IW-1:0] o_idx;
    logic [DW-1:0] o_data;

    typedef struct {
        bit            r;
        bit            m;
        logic [AW-1:0] a;
        bit            v;
        logic [DW-1:0] d;
        bit            eb;
        bit            er;
        logic [AW-1:0] ea;
        bit            ew;
        logic [IW-1:0] ei;
        bit            et;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return a & ~AW'(2 * WORDS - 1);
    endfunction

    function automatic vec_t mk(input bit r, m, input logic [AW-1:0] a, input bit v,
                                input logic [DW-1:0] d, input bit eb, er,
                                input logic [AW-1:0] ea, input bit ew,
                                input logic [IW-1:0] ei, input bit et);
        vec_t x;
        x.r = r; x.m = m; x.a = a; x.v = v; x.d = d;
        x.eb = eb; x.er = er; x.ea = ea; x.ew = ew; x.ei = ei; x.et = et;
        return x;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Compare current outputs against the model, then advance the model one edge.
    task automatic check_and_advance(input string name);
        bit            eb, er, ew, et, cp, bad;
        logic [AW-1:0] ea;
        logic [IW-1:0] ei;
        logic [DW-1:0] ed;
        eb = 0; er = 0; ew = 0; et = 0; cp = 0; ea = m_base; ei = '0; ed = '0;
        if (rst) begin
            ea = '0;
            cp = 1;
        end else if (!m_fill) begin
            eb = miss_detected;
        end else begin
            eb = 1;
            er = (m_nreq < WORDS);
            if (er) ea = m_base + AW'(2 * m_nreq);
            ew = mem_data_valid;
            if (ew) begin
                cp = 1;
                ei = IW'(m_nrecv % WORDS);
                ed = mem_data;
                et = (m_nrecv == WORDS - 1);
            end
        end
        o_busy = fsm_busy; o_req = mem_req; o_addr = mem_addr; o_wr = write_data_array;
        o_idx = data_word_idx; o_data = data_out; o_tag = write_tag_array; o_done = fill_done;
        bad = (o_busy !== eb) || (o_req !== er) || (o_addr !== ea) || (o_wr !== ew) ||
              (o_tag !== et) || (o_done !== et) || (cp && ((o_idx !== ei) || (o_data !== ed)));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s cyc %0d: got busy=%0b req=%0b addr=%h wr=%0b idx=%0d data=%h tag=%0b done=%0b; expected busy=%0b req=%0b addr=%h wr=%0b idx=%0d data=%h tag/done=%0b",
                     name, cyc, o_busy, o_req, o_addr, o_wr, o_idx, o_data, o_tag, o_done,
                     eb, er, ea, ew, ei, ed, et);
        end
        if (rst) begin
            m_fill = 0; m_base = '0; m_nreq = 0; m_nrecv = 0;
        end else if (!m_fill) begin
            if (miss_detected) begin
                m_fill = 1; m_base = line_of(miss_addr); m_nreq = 0; m_nrecv = 0;
            end
        end else begin
            if (er) m_nreq++;
            if (ew) begin
                m_nrecv++;
                if (m_nrecv == WORDS) m_fill = 0;
            end
        end
        cyc++;
    endtask

    // One clock of stimulus with the emulated memory answering requests.
    task automatic cycle(input bit r, input bit m, input logic [AW-1:0] a, input bit stray,
                         input string name);
        resp_t e;
        @(negedge clk);
        rst = r; miss_detected = m; miss_addr = a; mem_data_valid = 0; mem_data = '0;
        #1;
        if (r) begin
            pq.delete();
        end else if (mem_req) begin
            e.ready = cyc + int'($urandom_range(lat_max, lat_min));
            if (pq.size() > 0 && e.ready < pq[$].ready) e.ready = pq[$].ready;
            e.addr = mem_addr;
            pq.push_back(e);
        end
        gap_phase = ~gap_phase;
        if (!r && pq.size() > 0 && pq[0].ready <= cyc && !(gap_mode && gap_phase)) begin
            mem_data_valid = 1;
            mem_data       = pq[0].addr ^ 16'h5A5A;
            void'(pq.pop_front());
        end else if (!r && stray && !m_fill) begin
            mem_data_valid = 1;
            mem_data       = DW'($urandom);
        end
        #1;
        check_and_advance(name);
    endtask

    // Miss on addr, then run until fill_done; checks order, data, and timing.
    task automatic run_fill(input logic [AW-1:0] a, input int lmin, input int lmax,
                            input bit gap, input bit stray_first, input int exp_busy,
                            input string name);
        int            busy_n, wr_n, tag_n, req_n, first_req;
        logic [AW-1:0] first_a, last_a, base;
        bit            done;
        lat_min = lmin; lat_max = lmax; gap_mode = gap; gap_phase = 0;
        base = line_of(a);
        busy_n = 0; wr_n = 0; tag_n = 0; req_n = 0; first_req = -1; done = 0;
        first_a = '0; last_a = '0;
        for (int k = 0; k < 60 && !done; k++) begin
            cycle(1'b0, k == 0, a, (k == 0) && stray_first, name);
            if (o_busy) busy_n++;
            if (o_req) begin
                if (first_req < 0) begin
                    first_req = k;
                    first_a   = o_addr;
                end
                last_a = o_addr;
                req_n++;
            end
            if (o_wr) begin
                check_val({name, " word idx"}, 32'(o_idx), 32'(wr_n));
                check_val({name, " word data"}, 32'(o_data),
                          32'((base + AW'(2 * wr_n)) ^ 16'h5A5A));
                wr_n++;
            end
            if (o_tag) tag_n++;
            if (o_done) done = 1;
        end
        check_val({name, " completed"}, 32'(done), 32'd1);
        check_val({name, " writes"}, 32'(wr_n), 32'(WORDS));
        check_val({name, " tag writes"}, 32'(tag_n), 32'd1);
        check_val({name, " requests"}, 32'(req_n), 32'(WORDS));
        check_val({name, " first req cycle"}, 32'(first_req), 32'd1);
        check_val({name, " first addr"}, 32'(first_a), 32'(base));
        check_val({name, " last addr"}, 32'(last_a), 32'(base + AW'(2 * (WORDS - 1))));
        if (exp_busy > 0) check_val({name, " busy cycles"}, 32'(busy_n), 32'(exp_busy));
    endtask

    initial begin
        int wr_n, tag_n;
        rst = 1; miss_detected = 0; miss_addr = '0; mem_data_valid = 0; mem_data = '0;

        // Reset with busy inputs, then a zero-latency fill of 0x1234 and a stray word.
        tbl.push_back(mk(1, 1, 16'h1234, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'hFFFF, 1, 16'h1111, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h1234, 1, 16'hDEAD, 1, 0, 16'h0000, 0, 0, 0));
        for (int i = 0; i < WORDS; i++)
            tbl.push_back(mk(0, i == 3, 16'h8888, 1, 16'(16'h0100 + i), 1, 1,
                             16'(16'h1230 + 2 * i), 1, IW'(i), i == WORDS - 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h7777, 0, 0, 16'h1230, 0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; miss_detected = tbl[i].m; miss_addr = tbl[i].a;
            mem_data_valid = tbl[i].v; mem_data = tbl[i].d;
            #2;
            checks++;
            if (fsm_busy !== tbl[i].eb || mem_req !== tbl[i].er || mem_addr !== tbl[i].ea ||
                write_data_array !== tbl[i].ew || write_tag_array !== tbl[i].et ||
                fill_done !== tbl[i].et ||
                ((tbl[i].ew || tbl[i].r) && (data_word_idx !== tbl[i].ei ||
                                             data_out !== (tbl[i].r ? '0 : tbl[i].d)))) begin
                errors++;
                $display("FAIL vector %0d: got busy=%0b req=%0b addr=%h wr=%0b idx=%0d data=%h tag=%0b done=%0b; expected busy=%0b req=%0b addr=%h wr=%0b idx=%0d tag/done=%0b",
                         i, fsm_busy, mem_req, mem_addr, write_data_array, data_word_idx,
                         data_out, write_tag_array, fill_done, tbl[i].eb, tbl[i].er,
                         tbl[i].ea, tbl[i].ew, tbl[i].ei, tbl[i].et);
            end
            check_and_advance("vector model");
        end

        run_fill(16'h1234, 4, 4, 0, 0, 13, "latency4");
        run_fill(16'h4321, 0, 0, 0, 0, 9, "zero latency");
        run_fill(16'h0A0E, 0, 0, 1, 0, -1, "gapped");
        run_fill(16'hFFFA, 0, 0, 0, 0, 9, "top of space");

        // Reset after three data writes aborts the fill without a tag write.
        lat_min = 0; lat_max = 0; gap_mode = 0;
        wr_n = 0; tag_n = 0;
        cycle(0, 1, 16'h1234, 0, "abort miss");
        for (int k = 0; k < 20 && wr_n < 3; k++) begin
            cycle(0, 0, 16'h0000, 0, "abort fill");
            if (o_wr) wr_n++;
            if (o_tag) tag_n++;
        end
        check_val("abort writes before reset", 32'(wr_n), 32'd3);
        cycle(1, 1, 16'h5555, 1, "abort reset");
        if (o_tag) tag_n++;
        cycle(0, 0, 16'h0000, 1, "abort idle");
        if (o_tag || o_wr) tag_n++;
        check_val("abort no tag write", 32'(tag_n), 32'd0);
        run_fill(16'h1234, 0, 0, 0, 0, 9, "refill after abort");

        // Back-to-back misses; stray valid lands in the second miss cycle.
        run_fill(16'h1000, 1, 2, 0, 0, -1, "first of pair");
        run_fill(16'h2468, 0, 0, 0, 1, 9, "second of pair");

        // Randomized traffic against the model.
        lat_min = 0; lat_max = 3; gap_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(199, 0) == 0, $urandom_range(2, 0) == 0, AW'($urandom),
                  $urandom_range(1, 0) == 1, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
